// File: rtl/ensemble_pkg.sv
// Shared types and the 2-of-3 vote function for the ensemble voting stage.
// The vote works on labels zero-extended to MAX_CLASS_WIDTH so any label width up to 32 fits.
package ensemble_pkg;
  localparam int CLASS_WIDTH_DEFAULT = 8;
  localparam int MAX_CLASS_WIDTH     = 32;
  localparam int UNANIMOUS_BIT       = CLASS_WIDTH_DEFAULT;
  localparam int TIE_BIT             = CLASS_WIDTH_DEFAULT + 1;

  typedef struct packed {
    logic [MAX_CLASS_WIDTH-1:0] label;
    logic                       unanimous;
    logic                       tie;
    logic                       last;
  } vote_t;

  function automatic vote_t majority3(input logic [MAX_CLASS_WIDTH-1:0] a,
                                      input logic [MAX_CLASS_WIDTH-1:0] b,
                                      input logic [MAX_CLASS_WIDTH-1:0] c,
                                      input int tie_src);
    vote_t v;
    v.last      = 1'b0;
    v.unanimous = (a == b) && (b == c);
    v.tie       = (a != b) && (a != c) && (b != c);
    if ((a == b) || (a == c)) v.label = a;
    else if (b == c)          v.label = b;
    else begin
      case (tie_src)
        1:       v.label = a;
        2:       v.label = b;
        default: v.label = c;
      endcase
    end
    return v;
  endfunction
endpackage

// File: rtl/ensemble_out_fifo.sv
// Two-entry synchronous FIFO with valid/ready on both sides.
// A push is accepted while full if the head is popped in the same cycle.
module ensemble_out_fifo #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push_valid,
  output logic             o_push_ready,
  input  logic [WIDTH-1:0] i_push_data,
  output logic             o_pop_valid,
  input  logic             i_pop_ready,
  output logic [WIDTH-1:0] o_pop_data
);
  logic [WIDTH-1:0] r_mem [2];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_count;
  logic             w_push;
  logic             w_pop;

  assign o_pop_valid  = (r_count != 2'd0);
  assign o_push_ready = (r_count != 2'd2) | i_pop_ready;
  assign w_push       = i_push_valid & o_push_ready;
  assign w_pop        = o_pop_valid & i_pop_ready;
  assign o_pop_data   = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end
endmodule

// File: rtl/ensemble_vote.sv
// Joins one beat from each of three classifier streams and emits a 2-of-3 majority label,
// with agreement counters and a sticky flag for triples whose tlast bits disagree.
module ensemble_vote
  import ensemble_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int KEEP_WIDTH  = 4,
  parameter int CLASS_WIDTH = CLASS_WIDTH_DEFAULT,
  parameter int TIE_SRC     = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata_1,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep_1,
  input  logic                  s_axis_tvalid_1,
  output logic                  s_axis_tready_1,
  input  logic                  s_axis_tlast_1,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata_2,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep_2,
  input  logic                  s_axis_tvalid_2,
  output logic                  s_axis_tready_2,
  input  logic                  s_axis_tlast_2,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata_3,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep_3,
  input  logic                  s_axis_tvalid_3,
  output logic                  s_axis_tready_3,
  input  logic                  s_axis_tlast_3,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [31:0]           vote_count,
  output logic [31:0]           disagree_count,
  output logic                  last_mismatch
);
  // All streams: a beat transfers on the rising edge where tvalid & tready are both 1;
  // a source holds tvalid and its data stable until that edge, and tready never waits on tvalid.
  logic [CLASS_WIDTH-1:0] r_label [3];
  logic [2:0]             r_full;
  logic [2:0]             r_last;
  logic [31:0]            r_vote_count;
  logic [31:0]            r_disagree_count;
  logic                   r_last_mismatch;

  logic [CLASS_WIDTH-1:0] w_in_label [3];
  logic [2:0]             w_in_last;
  logic [2:0]             w_valid;
  logic [2:0]             w_ready;
  logic [2:0]             w_hs;
  logic                   w_fifo_ready;
  logic                   w_fire;
  vote_t                  w_vote;
  logic [DATA_WIDTH-1:0]  w_word;
  logic                   w_head_valid;
  logic [DATA_WIDTH:0]    w_head;
  logic                   w_unused;

  assign w_in_label[0] = s_axis_tdata_1[CLASS_WIDTH-1:0];
  assign w_in_label[1] = s_axis_tdata_2[CLASS_WIDTH-1:0];
  assign w_in_label[2] = s_axis_tdata_3[CLASS_WIDTH-1:0];
  assign w_in_last     = {s_axis_tlast_3, s_axis_tlast_2, s_axis_tlast_1};
  assign w_valid       = {s_axis_tvalid_3, s_axis_tvalid_2, s_axis_tvalid_1};

  // A slot can be refilled in the same cycle it is consumed, which sustains one result per cycle.
  assign w_fire  = (&r_full) & w_fifo_ready;
  assign w_ready = rst ? 3'b000 : (~r_full | {3{w_fire}});
  assign w_hs    = w_valid & w_ready;

  assign s_axis_tready_1 = w_ready[0];
  assign s_axis_tready_2 = w_ready[1];
  assign s_axis_tready_3 = w_ready[2];

  assign w_vote = majority3(MAX_CLASS_WIDTH'(r_label[0]), MAX_CLASS_WIDTH'(r_label[1]),
                            MAX_CLASS_WIDTH'(r_label[2]), TIE_SRC);

  always_comb begin
    w_word                    = '0;
    w_word[CLASS_WIDTH-1:0]   = w_vote.label[CLASS_WIDTH-1:0];
    w_word[CLASS_WIDTH]       = w_vote.unanimous;
    w_word[CLASS_WIDTH+1]     = w_vote.tie;
  end

  ensemble_out_fifo #(.WIDTH(DATA_WIDTH + 1)) u_out_fifo (
    .clk          (clk),
    .rst          (rst),
    .i_push_valid (&r_full),
    .o_push_ready (w_fifo_ready),
    .i_push_data  ({&r_last, w_word}),
    .o_pop_valid  (w_head_valid),
    .i_pop_ready  (m_axis_tready),
    .o_pop_data   (w_head)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 3; k++) r_label[k] <= '0;
      r_full           <= 3'b000;
      r_last           <= 3'b000;
      r_vote_count     <= '0;
      r_disagree_count <= '0;
      r_last_mismatch  <= 1'b0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (w_hs[k]) begin
          r_full[k]  <= 1'b1;
          r_label[k] <= w_in_label[k];
          r_last[k]  <= w_in_last[k];
        end else if (w_fire) begin
          r_full[k]  <= 1'b0;
        end
      end
      if (w_fire) begin
        r_vote_count     <= r_vote_count + 32'd1;
        r_disagree_count <= r_disagree_count + {31'b0, ~w_vote.unanimous};
        if ((|r_last) && !(&r_last)) r_last_mismatch <= 1'b1;
      end
    end
  end

  assign m_axis_tvalid  = w_head_valid;
  assign m_axis_tdata   = w_head_valid ? w_head[DATA_WIDTH-1:0] : '0;
  assign m_axis_tlast   = w_head_valid & w_head[DATA_WIDTH];
  assign m_axis_tkeep   = w_head_valid ? '1 : '0;
  assign vote_count     = r_vote_count;
  assign disagree_count = r_disagree_count;
  assign last_mismatch  = r_last_mismatch;

  assign w_unused = ^{s_axis_tkeep_1, s_axis_tkeep_2, s_axis_tkeep_3, w_vote,
                      s_axis_tdata_1[DATA_WIDTH-1:CLASS_WIDTH],
                      s_axis_tdata_2[DATA_WIDTH-1:CLASS_WIDTH],
                      s_axis_tdata_3[DATA_WIDTH-1:CLASS_WIDTH]};
endmodule

// File: tb/tb_ensemble_vote.sv
// Bench for ensemble_vote: per-stream beat queues feed a triple-joining vote model,
// and a compare process checks every emitted word against the expected queue.
module tb_ensemble_vote;
  localparam int DW = 32;
  localparam int KW = 4;
  localparam int CW = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [DW-1:0] d [3];
  logic [KW-1:0] kp [3];
  logic [2:0]    vld;
  logic [2:0]    lst;
  logic          rdy_1, rdy_2, rdy_3;
  logic [2:0]    rdy;
  logic          m_tready;
  logic [DW-1:0] m_tdata;
  logic [KW-1:0] m_tkeep;
  logic          m_tvalid, m_tlast;
  logic [31:0]   vote_count, disagree_count;
  logic          last_mismatch;
  // second instance, tie broken toward classifier 1
  logic          b_rdy_1, b_rdy_2, b_rdy_3;
  logic [DW-1:0] b_tdata;
  logic [KW-1:0] b_tkeep;
  logic          b_tvalid, b_tlast;
  logic [31:0]   b_vote_count, b_disagree_count;
  logic          b_last_mismatch;

  assign rdy = {rdy_3, rdy_2, rdy_1};

  ensemble_vote #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .CLASS_WIDTH(CW), .TIE_SRC(3)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata_1(d[0]), .s_axis_tkeep_1(kp[0]), .s_axis_tvalid_1(vld[0]),
    .s_axis_tready_1(rdy_1), .s_axis_tlast_1(lst[0]),
    .s_axis_tdata_2(d[1]), .s_axis_tkeep_2(kp[1]), .s_axis_tvalid_2(vld[1]),
    .s_axis_tready_2(rdy_2), .s_axis_tlast_2(lst[1]),
    .s_axis_tdata_3(d[2]), .s_axis_tkeep_3(kp[2]), .s_axis_tvalid_3(vld[2]),
    .s_axis_tready_3(rdy_3), .s_axis_tlast_3(lst[2]),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready), .m_axis_tlast(m_tlast),
    .vote_count(vote_count), .disagree_count(disagree_count), .last_mismatch(last_mismatch)
  );

  ensemble_vote #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .CLASS_WIDTH(CW), .TIE_SRC(1)) dut_t1 (
    .clk(clk), .rst(rst),
    .s_axis_tdata_1(d[0]), .s_axis_tkeep_1(kp[0]), .s_axis_tvalid_1(vld[0]),
    .s_axis_tready_1(b_rdy_1), .s_axis_tlast_1(lst[0]),
    .s_axis_tdata_2(d[1]), .s_axis_tkeep_2(kp[1]), .s_axis_tvalid_2(vld[1]),
    .s_axis_tready_2(b_rdy_2), .s_axis_tlast_2(lst[1]),
    .s_axis_tdata_3(d[2]), .s_axis_tkeep_3(kp[2]), .s_axis_tvalid_3(vld[2]),
    .s_axis_tready_3(b_rdy_3), .s_axis_tlast_3(lst[2]),
    .m_axis_tdata(b_tdata), .m_axis_tkeep(b_tkeep), .m_axis_tvalid(b_tvalid),
    .m_axis_tready(m_tready), .m_axis_tlast(b_tlast),
    .vote_count(b_vote_count), .disagree_count(b_disagree_count),
    .last_mismatch(b_last_mismatch)
  );

  // ---------------- bench state ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int n_out    = 0;
  logic [DW:0]   src_q [3][$];     // pending beats {tlast, tdata}
  logic [CW:0]   in_q  [3][$];     // accepted beats {tlast, label}
  logic [DW:0]   exp_q [$];        // expected {tlast, tdata}, TIE_SRC=3
  logic [DW-1:0] exp1_q [$];       // expected tdata, TIE_SRC=1
  logic [2:0]    hs;
  logic [2:0]    en;
  int            p_val;
  int            mrdy_mode;        // 0: held low, 1: held high, 2: random
  int            mdl_votes, mdl_dis;
  logic          mdl_mm;
  logic [DW:0]   last_out;
  logic [DW-1:0] last_out1;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endfunction

  // Majority from occurrence counts: the first label seen at least twice wins.
  function automatic logic [DW-1:0] model_word(input int a, input int b, input int c, input int tie_src);
    int lab [3];
    int best;
    int cnt;
    logic unan;
    lab[0] = a; lab[1] = b; lab[2] = c;
    best = -1;
    for (int i = 0; i < 3; i++) begin
      cnt = 0;
      for (int j = 0; j < 3; j++) if (lab[j] == lab[i]) cnt++;
      if (cnt >= 2 && best < 0) best = lab[i];
    end
    unan = (a == b) && (a == c);
    if (best < 0) return 32'h200 | 32'(lab[tie_src-1]);
    return (unan ? 32'h100 : 32'h0) | 32'(best);
  endfunction

  function automatic void push_triple(input int l1, input int l2, input int l3,
                                      input bit t1, input bit t2, input bit t3);
    src_q[0].push_back({t1, 24'($urandom), 8'(l1)});
    src_q[1].push_back({t2, 24'($urandom), 8'(l2)});
    src_q[2].push_back({t3, 24'($urandom), 8'(l3)});
  endfunction

  function automatic void join_model();
    logic [CW:0] a, b, c;
    logic [DW-1:0] w;
    while (in_q[0].size() > 0 && in_q[1].size() > 0 && in_q[2].size() > 0) begin
      a = in_q[0].pop_front();
      b = in_q[1].pop_front();
      c = in_q[2].pop_front();
      w = model_word(int'(a[CW-1:0]), int'(b[CW-1:0]), int'(c[CW-1:0]), 3);
      exp_q.push_back({a[CW] & b[CW] & c[CW], w});
      exp1_q.push_back(model_word(int'(a[CW-1:0]), int'(b[CW-1:0]), int'(c[CW-1:0]), 1));
      mdl_votes++;
      if (!((a[CW-1:0] == b[CW-1:0]) && (a[CW-1:0] == c[CW-1:0]))) mdl_dis++;
      if ((a[CW] != b[CW]) || (b[CW] != c[CW])) mdl_mm = 1'b1;
    end
  endfunction

  // ---------------- driver ----------------
  // Drives one cycle at the falling edge; returns 1 time unit later with hs[] holding
  // the beats that will transfer on the coming rising edge.
  task automatic step();
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      if (hs[k]) begin
        void'(src_q[k].pop_front());
        vld[k] = 1'b0;
      end
      if (!vld[k] && en[k] && src_q[k].size() > 0 && $urandom_range(99) < p_val) vld[k] = 1'b1;
      if (vld[k]) begin
        d[k]   = src_q[k][0][DW-1:0];
        lst[k] = src_q[k][0][DW];
      end else begin
        d[k]   = $urandom;
        lst[k] = 1'($urandom_range(1));
      end
      kp[k] = 4'($urandom);
    end
    case (mrdy_mode)
      0:       m_tready = 1'b0;
      1:       m_tready = 1'b1;
      default: m_tready = 1'($urandom_range(1));
    endcase
    #1;
    hs = vld & rdy;
    for (int k = 0; k < 3; k++) if (hs[k]) in_q[k].push_back({lst[k], d[k][CW-1:0]});
    join_model();
  endtask

  function automatic bit is_idle();
    return (src_q[0].size() == 0) && (src_q[1].size() == 0) && (src_q[2].size() == 0) &&
           (vld == 3'b000) && (exp_q.size() == 0);
  endfunction

  task automatic drain(input string name);
    int cyc;
    cyc = 0;
    while (!is_idle() && cyc < 3000) begin
      step();
      cyc++;
    end
    chk({name, "_drained"}, 64'(is_idle()), 64'd1);
    repeat (3) step();
    chk({name, "_vote_count"}, 64'(vote_count), 64'(mdl_votes));
    chk({name, "_disagree_count"}, 64'(disagree_count), 64'(mdl_dis));
    chk({name, "_last_mismatch"}, 64'(last_mismatch), 64'(mdl_mm));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      src_q[k].delete();
      in_q[k].delete();
    end
    exp_q.delete();
    exp1_q.delete();
    vld = 3'b000; hs = 3'b000; m_tready = 1'b0;
    mdl_votes = 0; mdl_dis = 0; mdl_mm = 1'b0;
    #1;
    chk("rst_tready_low", 64'(rdy), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_tdata_tlast", 64'({m_tlast, m_tdata}), 64'd0);
    chk("rst_tkeep", 64'(m_tkeep), 64'd0);
    chk("rst_counters", {vote_count, disagree_count}, 64'd0);
    chk("rst_last_mismatch", 64'(last_mismatch), 64'd0);
    chk("rst_tready_after", 64'(rdy), 64'd7);
  endtask

  // ---------------- scoreboard / compare ----------------
  always begin
    logic [DW:0] e;
    @(negedge clk);
    #2;
    if (!rst) begin
      chk("tkeep", 64'(m_tkeep), m_tvalid ? 64'hF : 64'h0);
      if (!m_tvalid) chk("idle_tdata", 64'({m_tlast, m_tdata}), 64'd0);
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL extra_output: got 0x%0h expected no output", m_tdata);
        end else begin
          e = exp_q.pop_front();
          chk("tdata", 64'(m_tdata), 64'(e[DW-1:0]));
          chk("tlast", 64'(m_tlast), 64'(e[DW]));
          chk("tie1_tvalid", 64'(b_tvalid), 64'd1);
          chk("tie1_tdata", 64'(b_tdata), 64'(exp1_q.pop_front()));
          last_out  = {m_tlast, m_tdata};
          last_out1 = b_tdata;
          n_out++;
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    int n0;
    vld = 3'b000; lst = 3'b000; hs = 3'b000; en = 3'b111;
    p_val = 100; mrdy_mode = 1; m_tready = 1'b0;
    mdl_votes = 0; mdl_dis = 0; mdl_mm = 1'b0;
    for (int k = 0; k < 3; k++) begin
      d[k] = '0;
      kp[k] = '0;
    end

    chk("model_555", 64'(model_word(5, 5, 5, 3)), 64'h105);
    chk("model_272", 64'(model_word(2, 7, 2, 3)), 64'h002);
    chk("model_499", 64'(model_word(4, 9, 9, 3)), 64'h009);
    chk("model_123_t3", 64'(model_word(1, 2, 3, 3)), 64'h203);
    chk("model_123_t1", 64'(model_word(1, 2, 3, 1)), 64'h201);

    do_reset();

    // unanimous triple, latency of one edge after the joining handshake
    push_triple(5, 5, 5, 0, 0, 0);
    step();
    chk("t1_all_ready", 64'(hs), 64'd7);
    step();
    chk("t1_no_early_valid", 64'(m_tvalid), 64'd0);
    step();
    chk("t1_valid", 64'(m_tvalid), 64'd1);
    chk("t1_tdata", 64'(m_tdata), 64'h105);
    drain("t1");
    chk("t1_votes_lit", 64'(vote_count), 64'd1);
    chk("t1_dis_lit", 64'(disagree_count), 64'd0);

    // majority with disagreement
    push_triple(2, 7, 2, 0, 0, 0);
    push_triple(4, 9, 9, 0, 0, 0);
    drain("t2");
    chk("t2_last_word", 64'(last_out), 64'h009);
    chk("t2_dis_lit", 64'(disagree_count), 64'd2);

    // three-way tie
    push_triple(1, 2, 3, 0, 0, 0);
    drain("t3");
    chk("t3_tie_src3", 64'(last_out), 64'h203);
    chk("t3_tie_src1", 64'(last_out1), 64'h201);

    // staggered arrival, classifier 1 offering a second beat early
    src_q[0].push_back({1'b0, 24'($urandom), 8'd6});
    src_q[0].push_back({1'b0, 24'($urandom), 8'd6});
    src_q[1].push_back({1'b0, 24'($urandom), 8'd6});
    src_q[2].push_back({1'b0, 24'($urandom), 8'd8});
    n0 = n_out;
    for (int c = 0; c <= 11; c++) begin
      en = {1'(c >= 9), 1'(c >= 4), 1'b1};
      step();
      chk($sformatf("stag_ready1_c%0d", c), 64'(rdy[0]), 64'((c == 0) || (c == 10)));
      chk($sformatf("stag_tvalid_c%0d", c), 64'(m_tvalid), 64'(c == 11));
    end
    en = 3'b111;
    src_q[1].push_back({1'b0, 24'($urandom), 8'd6});
    src_q[2].push_back({1'b0, 24'($urandom), 8'd7});
    drain("stag");
    chk("stag_outputs", 64'(n_out - n0), 64'd2);

    // downstream backpressure while six triples stream in
    mrdy_mode = 0;
    for (int i = 0; i < 6; i++)
      push_triple($urandom_range(3), $urandom_range(3), $urandom_range(3), 0, 0, 0);
    n0 = n_out;
    repeat (10) step();
    chk("bp_head_valid", 64'(m_tvalid), 64'd1);
    chk("bp_slots_held", 64'(rdy), 64'd0);
    chk("bp_triples_taken", 64'(exp_q.size()), 64'd3);
    mrdy_mode = 1;
    drain("bp");
    chk("bp_outputs", 64'(n_out - n0), 64'd6);

    // randomized traffic with consistent tlast
    mrdy_mode = 2;
    p_val = 60;
    for (int i = 0; i < 40; i++) begin
      bit t;
      t = 1'($urandom_range(1));
      if (i % 5 == 0) push_triple($urandom_range(255), $urandom_range(255), $urandom_range(255), t, t, t);
      else push_triple($urandom_range(3), $urandom_range(3), $urandom_range(3), t, t, t);
    end
    drain("rand");
    chk("rand_no_mismatch", 64'(last_mismatch), 64'd0);

    // unequal tlast on one triple
    mrdy_mode = 1;
    p_val = 100;
    push_triple(3, 3, 3, 1, 1, 0);
    drain("tl");
    chk("tl_tlast", 64'(last_out[DW]), 64'd0);
    chk("tl_mismatch_set", 64'(last_mismatch), 64'd1);
    mrdy_mode = 2;
    p_val = 70;
    for (int i = 0; i < 10; i++)
      push_triple($urandom_range(3), $urandom_range(3), $urandom_range(3), 1, 1, 1);
    drain("tl2");
    chk("tl_mismatch_sticky", 64'(last_mismatch), 64'd1);

    // reset with slots and FIFO occupied
    mrdy_mode = 0;
    p_val = 100;
    for (int i = 0; i < 6; i++) push_triple(i, i, 1, 1, 1, 1);
    repeat (5) step();
    chk("mid_fifo_occupied", 64'(m_tvalid), 64'd1);
    do_reset();
    mrdy_mode = 1;
    push_triple(5, 5, 5, 0, 0, 0);
    drain("post_rst");
    chk("post_rst_word", 64'(last_out), 64'h105);
    chk("post_rst_votes_lit", 64'(vote_count), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
